tt_um_jimktrains_vslc_keypad_scan: RTL

Scanned 4x4 hex-keypad reader for the iCEbreaker PMOD. It is the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad column low at a time, samples the four row lines, and debounces the full 16-key snapshot. Each clean single-key press is delivered as a 4-bit hex code over a valid/ready handshake, ready to feed the core's `ui_in`.

---
 rtl/vslc_keypad_pkg.sv | 68 ++++++
 rtl/vslc_sync2.sv | 29 ++
 rtl/tt_um_jimktrains_vslc_keypad_scan.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vslc_keypad_pkg.sv
// Shared types and helpers for the scanned 4x4 hex keypad reader.
// Holds the key FSM states, the population classes of a snapshot and the keypad layout.
package vslc_keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_MULTI = 2'd2
    } key_state_t;

    typedef enum logic [1:0] {
        OH_ZERO = 2'd0,
        OH_ONE  = 2'd1,
        OH_MANY = 2'd2
    } onehot_t;

    // Keypad layout: index is 4*row + column.
    function automatic logic [3:0] keymap(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic onehot_t onehot16(input logic [15:0] v);
        onehot_t cls;
        if (v == 16'h0000) begin
            cls = OH_ZERO;
        end else if ((v & (v - 16'd1)) == 16'h0000) begin
            cls = OH_ONE;
        end else begin
            cls = OH_MANY;
        end
        return cls;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] bit_index16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vslc_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// The reset value is a parameter so idle lines can come up in their released state.
module vslc_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/tt_um_jimktrains_vslc_keypad_scan.sv
// Scanned 4x4 hex keypad reader: column drive, row sampling, frame debounce,
// single-key FSM and a valid/ready output with a sticky overrun flag.
module tt_um_jimktrains_vslc_keypad_scan
    import vslc_keypad_pkg::*;
#(
    parameter int SCAN_DIV = 64,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

    logic [3:0]       row_n_sync_s;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       col_r;
    logic [1:0]       col_nxt_s;
    logic [3:0]       col_n_r;
    logic             slot_last_s;
    logic             frame_end_s;
    logic [15:0]      snap_r;
    logic [15:0]      snap_nxt_s;
    logic [15:0]      prev_raw_r;
    logic [15:0]      deb_r;
    logic [15:0]      deb_nxt_s;
    logic [3:0]       same_cnt_r;
    logic [3:0]       same_nxt_s;
    logic             deb_load_s;
    onehot_t          deb_cls_s;
    key_state_t       state_r;
    key_state_t       state_nxt_s;
    logic             emit_s;
    logic [3:0]       emit_code_s;
    logic             accept_s;
    logic [3:0]       key_code_r;
    logic [3:0]       key_code_nxt_s;
    logic             key_valid_r;
    logic             key_valid_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;
    logic             key_held_r;

    // Rows idle high through the pull-ups, so reset the synchronizer to all-released.
    vslc_sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk (CLK),
        .rst (rst),
        .d   (row_n),
        .q   (row_n_sync_s)
    );

    assign row_s       = ~row_n_sync_s;
    assign slot_last_s = (div_cnt_r == DIV_LAST);
    assign frame_end_s = slot_last_s && (col_r == 2'd3);
    assign col_nxt_s   = col_r + 2'd1;

    // Slot timer and column pointer; column drive is registered alongside the pointer.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            col_r     <= 2'd0;
            col_n_r   <= 4'b1110;
        end else if (slot_last_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            col_r     <= col_nxt_s;
            col_n_r   <= ~(4'b0001 << col_nxt_s);
        end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            col_r     <= col_r;
            col_n_r   <= col_n_r;
        end
    end

    // Snapshot with the current column's rows merged in; at frame end this is the raw frame.
    always_comb begin
        snap_nxt_s = snap_r;
        if (slot_last_s) begin
            for (int r = 0; r < 4; r++) begin
                snap_nxt_s[{2'(r), col_r}] = row_s[r];
            end
        end else begin
            snap_nxt_s = snap_r;
        end
    end

    // Frame-to-frame agreement counter, saturating at the debounce depth.
    always_comb begin
        same_nxt_s = same_cnt_r;
        if (snap_nxt_s != prev_raw_r) begin
            same_nxt_s = 4'd1;
        end else if (same_cnt_r >= DEB_MAX) begin
            same_nxt_s = DEB_MAX;
        end else begin
            same_nxt_s = same_cnt_r + 4'd1;
        end
    end

    assign deb_load_s = frame_end_s && (same_nxt_s == DEB_MAX);
    assign deb_nxt_s  = deb_load_s ? snap_nxt_s : deb_r;
    assign deb_cls_s  = onehot16(deb_nxt_s);
    assign emit_code_s = keymap(bit_index16(deb_nxt_s));

    // Snapshot, previous frame and debounced state registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            snap_r     <= 16'h0000;
            prev_raw_r <= 16'h0000;
            same_cnt_r <= 4'd0;
            deb_r      <= 16'h0000;
        end else if (frame_end_s) begin
            snap_r     <= snap_nxt_s;
            prev_raw_r <= snap_nxt_s;
            same_cnt_r <= same_nxt_s;
            deb_r      <= deb_nxt_s;
        end else begin
            snap_r     <= snap_nxt_s;
            prev_raw_r <= prev_raw_r;
            same_cnt_r <= same_cnt_r;
            deb_r      <= deb_r;
        end
    end

    // Key FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Key FSM transitions; only a debounced update moves it, and only IDLE emits.
    always_comb begin
        state_nxt_s = state_r;
        emit_s      = 1'b0;
        if (deb_load_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (deb_cls_s == OH_ONE) begin
                        state_nxt_s = ST_HELD;
                        emit_s      = 1'b1;
                    end else if (deb_cls_s == OH_MANY) begin
                        state_nxt_s = ST_MULTI;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (deb_cls_s == OH_ZERO) begin
                        state_nxt_s = ST_IDLE;
                    end else if (deb_cls_s == OH_MANY) begin
                        state_nxt_s = ST_MULTI;
                    end else begin
                        state_nxt_s = ST_HELD;
                    end
                end
                ST_MULTI: begin
                    if (deb_cls_s == OH_ZERO) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_MULTI;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign accept_s = key_valid_r && key_ready;

    // Output handshake: a fresh code needs a free or draining slot, otherwise it is dropped.
    always_comb begin
        key_valid_nxt_s = key_valid_r;
        key_code_nxt_s  = key_code_r;
        overrun_nxt_s   = overrun_r;
        if (emit_s && (!key_valid_r || accept_s)) begin
            key_valid_nxt_s = 1'b1;
            key_code_nxt_s  = emit_code_s;
            overrun_nxt_s   = accept_s ? 1'b0 : overrun_r;
        end else if (emit_s) begin
            overrun_nxt_s   = 1'b1;
        end else if (accept_s) begin
            key_valid_nxt_s = 1'b0;
            overrun_nxt_s   = 1'b0;
        end else begin
            key_valid_nxt_s = key_valid_r;
            key_code_nxt_s  = key_code_r;
            overrun_nxt_s   = overrun_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            key_code_r  <= key_code_nxt_s;
            key_valid_r <= key_valid_nxt_s;
            overrun_r   <= overrun_nxt_s;
            key_held_r  <= (state_nxt_s == ST_HELD);
        end
    end

    assign col_n     = col_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign overrun   = overrun_r;
    assign key_held  = key_held_r;

endmodule
